btog_stream: RTL and testbench
==============================

BTOG_STREAM -- requirements
Module: btog_stream

Interface
REQ-001 SHALL have parameter W, default 4, the code width in bits (W >= 2).
REQ-002 SHALL have parameter CW, default 8, the transfer-counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port b, input, W bits: the binary word to encode.
REQ-006 SHALL have port in_valid, input, 1 bit: b is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept b this cycle.
REQ-008 SHALL have port g, output, W bits: the Gray-coded word at the head of the buffer.
REQ-009 SHALL have port out_valid, output, 1 bit: g is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes g this cycle.
REQ-011 SHALL have port xfer_cnt, output, CW bits: count of completed output transfers.

Function
REQ-012 SHALL encode g[W-1] = b[W-1] and g[i] = b[i+1] ^ b[i] for i = 0..W-2.
REQ-013 SHALL count an input transfer when in_valid && in_ready at a rising edge; the encoded value SHALL then be stored in a 2-entry FIFO buffer.
REQ-014 SHALL count an output transfer when out_valid && out_ready at a rising edge; the head entry SHALL then be removed.
REQ-015 SHALL have a latency of 1 cycle: a word accepted at edge t into an empty buffer SHALL appear on g with out_valid = 1 immediately after edge t.
REQ-016 SHALL drive in_ready = (occupancy < 2) && !rst, combinationally from registered state only and never from in_valid or out_ready.
REQ-017 SHALL drive out_valid = (occupancy > 0); g SHALL be the head entry, registered, with no combinational path from b.
REQ-018 SHALL track occupancy as 0/1/2, updated as follows:
  - input transfer only: +1
  - output transfer only: -1
  - both in the same cycle: unchanged, with head and tail moving together
  - neither: unchanged
REQ-019 SHALL sustain 1 word per cycle when out_ready is held high.
REQ-020 SHALL, when full (occupancy 2), hold in_ready = 0; in_valid SHALL then be ignored and SHALL NOT overwrite any stored entry.
REQ-021 SHALL, when empty, ignore out_ready and leave xfer_cnt unchanged.
REQ-022 SHALL deliver words strictly in acceptance order; no word SHALL be dropped or duplicated.
REQ-023 SHALL hold g and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL increment xfer_cnt by 1 on every output transfer, wrapping from 2^CW-1 to 0 with no flag.
REQ-025 SHALL leave the value of g unspecified when out_valid = 0; the implementation SHALL drive g to 0 in that case.

Reset
REQ-026 SHALL, while rst = 1 at a rising edge, clear the following, taking priority over any simultaneous transfer:
  - occupancy to 0
  - FIFO pointers to 0
  - g to 0
  - out_valid to 0
  - xfer_cnt to 0
REQ-027 SHALL hold in_ready = 0 while rst = 1 and drive it to 1 in the first cycle after rst deasserts.
REQ-028 SHALL, on reset mid-operation, discard all buffered words; none SHALL appear after reset.
REQ-029 SHALL not count any transfer attempted in a cycle where rst = 1.

Verification
REQ-030 Single word: with out_ready = 1, drive b = 4'b0110 with in_valid for 1 cycle -> next cycle g = 4'b0101, out_valid = 1, xfer_cnt = 1.
REQ-031 Exhaustive streaming: drive b = 0..15 back-to-back with out_ready = 1 -> g follows 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 at 1 word/cycle, and adjacent outputs differ in exactly one bit.
REQ-032 Backpressure: with out_ready = 0, offer 4'b1111, 4'b1011, 4'b0001 -> first two accepted, in_ready = 0 while the third is held; on raising out_ready, outputs are 4'b1000, 4'b1110, 4'b0001 in order.
REQ-033 Simultaneous accept and drain at occupancy 1 -> occupancy stays 1, in_ready stays 1, order preserved.
REQ-034 Counter wrap (CW = 8): 256 output transfers -> xfer_cnt returns to 0.
REQ-035 Reset mid-operation: buffer full, assert rst for 1 cycle -> out_valid = 0, g = 0, xfer_cnt = 0, in_ready = 0 during rst and 1 after; no stale word is emitted.

Source files
------------

// File: rtl/btog_stream.sv
// btog_stream: binary-to-Gray encoder feeding a 2-entry valid/ready FIFO.
module btog_stream #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  g,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] xfer_cnt
);
    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;
    logic [1:0]   occ;
    logic         push, pop;
    logic [W-1:0] enc;
    always_comb begin
        enc       = b ^ (b >> 1);
        in_ready  = !occ[1] && !rst;
        out_valid = occ != 2'd0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // g comes straight from storage, never from b; forced to 0 when empty
        g         = out_valid ? mem[rd_ptr] : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= enc;
    end
endmodule

// File: tb/tb_btog_stream.sv
// tb_btog_stream: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_btog_stream;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [3:0] b;
    logic       in_ready, out_valid;
    logic [3:0] g;
    logic [7:0] xfer_cnt;
    int tests = 0;
    int fails = 0;
    logic [3:0] mq[$];
    logic [7:0] mcnt = 8'd0;

    btog_stream #(.W(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .g(g), .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i == 3) ? x[3] : (x[i+1] ^ x[i]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle from a negedge, step the model, check at the next negedge.
    task automatic cycle(input bit r, input bit v, input logic [3:0] bb, input bit o);
        bit acc, take;
        rst = r; in_valid = v; b = bb; out_ready = o;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!r && mq.size() < 2)});
        acc  = !r && v && mq.size() < 2;
        take = !r && o && mq.size() > 0;
        if (r) begin
            mq.delete();
            mcnt = 8'd0;
        end else begin
            if (take) begin
                void'(mq.pop_front());
                mcnt = mcnt + 8'd1;
            end
            if (acc) mq.push_back(gray(bb));
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("g", {28'd0, g}, {28'd0, (mq.size() > 0) ? mq[0] : 4'd0});
        chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, mcnt});
    endtask

    typedef struct {
        bit r, v; logic [3:0] bb; bit o;
        bit ir; logic [3:0] eg; bit eov; logic [7:0] ecnt;
    } vec_t;
    vec_t tbl[9];
    logic [3:0] gexp[16];
    logic [3:0] prev;

    initial begin
        rst = 1'b1; in_valid = 1'b0; b = 4'd0; out_ready = 1'b0;
        tbl[0] = '{1, 1, 4'hF, 1, 0, 4'h0, 0, 8'd0};
        tbl[1] = '{0, 1, 4'h6, 1, 1, 4'h5, 1, 8'd0};
        tbl[2] = '{0, 0, 4'h0, 1, 1, 4'h0, 0, 8'd1};
        tbl[3] = '{0, 1, 4'hF, 0, 1, 4'h8, 1, 8'd1};
        tbl[4] = '{0, 1, 4'hB, 0, 1, 4'h8, 1, 8'd1};
        tbl[5] = '{0, 1, 4'h1, 0, 0, 4'h8, 1, 8'd1};
        tbl[6] = '{0, 1, 4'h1, 1, 0, 4'hE, 1, 8'd2};
        tbl[7] = '{0, 1, 4'h1, 1, 1, 4'h1, 1, 8'd3};
        tbl[8] = '{0, 0, 4'h0, 1, 1, 4'h0, 0, 8'd4};
        gexp = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        @(negedge clk);
        cycle(1, 0, 4'd0, 0);

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d_ir", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
            cycle(tbl[i].r, tbl[i].v, tbl[i].bb, tbl[i].o);
            chk($sformatf("tbl%0d_g", i), {28'd0, g}, {28'd0, tbl[i].eg});
            chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
            chk($sformatf("tbl%0d_cnt", i), {24'd0, xfer_cnt}, {24'd0, tbl[i].ecnt});
        end

        prev = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, i[3:0], 1);
            chk($sformatf("stream%0d", i), {28'd0, g}, {28'd0, gexp[i]});
            chk("stream_ov", {31'd0, out_valid}, 32'd1);
            if (i > 0) chk("one_bit", $countones(g ^ prev), 32'd1);
            prev = g;
        end
        cycle(0, 0, 4'd0, 1);

        cycle(1, 0, 4'd0, 0);
        for (int i = 0; i < 256; i++) cycle(0, 1, $urandom_range(0, 15), 1);
        cycle(0, 0, 4'd0, 1);
        chk("wrap", {24'd0, xfer_cnt}, 32'd0);

        cycle(0, 1, 4'h3, 0);
        cycle(0, 1, 4'hC, 0);
        chk("full_ir", {31'd0, in_ready}, 32'd0);
        cycle(1, 1, 4'h5, 1);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_g", {28'd0, g}, 32'd0);
        chk("rst_cnt", {24'd0, xfer_cnt}, 32'd0);
        cycle(0, 0, 4'd0, 1);
        chk("post_rst_ov", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15), $urandom_range(0, 2) != 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
